// File: rtl/par_bus_pkg.sv
// Shared encodings and defaults for the parallel bus slave and its FIFOs.
package par_bus_pkg;

    localparam logic [1:0] ST_UNSYNC     = 2'd0;
    localparam logic [1:0] ST_SYNC0_SEEN = 2'd1;
    localparam logic [1:0] ST_ACTIVE     = 2'd2;

    localparam logic [7:0] SYNC_WORD0_DEFAULT = 8'hB8;
    localparam logic [7:0] SYNC_WORD1_DEFAULT = 8'h8B;

    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/par_bus_fifo.sv
// Synchronous FWFT FIFO: head visible combinationally, push/pop take effect at the next clk edge.
// A pop frees space for a same-cycle push when full; a push into a full FIFO without a pop is dropped.
module par_bus_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/par_bus_slave.sv
// Parallel bus slave: locks on a two-word sync pattern, then writes land in RX FIFO (4 clk after strobe)
// and read strobes drain the TX FIFO onto the pad; full RX drops words (sticky flag), empty TX sends fill.
module par_bus_slave
    import par_bus_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    RX_DEPTH   = 16,
    parameter int                    TX_DEPTH   = 16,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD0 = DATA_WIDTH'(SYNC_WORD0_DEFAULT),
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD1 = DATA_WIDTH'(SYNC_WORD1_DEFAULT),
    parameter int                    SYNC_HOLD  = 2,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        bus_clk,
    input  logic                        bus_rnw,
    input  logic [DATA_WIDTH-1:0]       bus_data_in,
    output logic [DATA_WIDTH-1:0]       bus_data_out,
    output logic                        bus_data_oe,
    input  logic                        resync,
    input  logic                        clear_flags,
    output logic [DATA_WIDTH-1:0]       rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    input  logic [DATA_WIDTH-1:0]       tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        synced,
    output logic                        rx_overflow,
    output logic                        tx_underflow,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    output logic [$clog2(TX_DEPTH):0]   tx_count
);

    logic                  bclk_s1, bclk_s2, bclk_s3;
    logic                  rnw_s1, rnw_s2;
    logic [DATA_WIDTH-1:0] din_s1, din_s2;
    logic                  bclk_rise, bclk_fall;

    logic [1:0]            state;
    logic [7:0]            hold_cnt;
    logic                  hold_done;
    logic                  active;

    logic                  rx_req;
    logic [DATA_WIDTH-1:0] rx_word;
    logic                  rx_push, rx_pop, rx_empty, rx_full;
    logic                  tx_take, tx_pop, tx_push, tx_empty, tx_full;
    logic [DATA_WIDTH-1:0] tx_head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bclk_s1 <= 1'b0;
            bclk_s2 <= 1'b0;
            bclk_s3 <= 1'b0;
            rnw_s1  <= 1'b0;
            rnw_s2  <= 1'b0;
            din_s1  <= '0;
            din_s2  <= '0;
        end else begin
            bclk_s1 <= bus_clk;
            bclk_s2 <= bclk_s1;
            bclk_s3 <= bclk_s2;
            rnw_s1  <= bus_rnw;
            rnw_s2  <= rnw_s1;
            din_s1  <= bus_data_in;
            din_s2  <= din_s1;
        end
    end

    assign bclk_rise = bclk_s2 && !bclk_s3;
    assign bclk_fall = !bclk_s2 && bclk_s3;
    assign hold_done = (hold_cnt == 8'(SYNC_HOLD - 1));
    assign active    = (state == ST_ACTIVE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_UNSYNC;
            hold_cnt <= '0;
        end else if (resync) begin
            state    <= ST_UNSYNC;
            hold_cnt <= '0;
        end else begin
            case (state)
                ST_UNSYNC: begin
                    if (bclk_s2 && !rnw_s2 && din_s2 == SYNC_WORD0) begin
                        if (hold_done) begin
                            state    <= ST_SYNC0_SEEN;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end else begin
                        hold_cnt <= '0;
                    end
                end
                ST_SYNC0_SEEN: begin
                    // Lingering first word is tolerated; anything else breaks the pattern.
                    if (!bclk_s2 || (din_s2 != SYNC_WORD0 && din_s2 != SYNC_WORD1)) begin
                        state    <= ST_UNSYNC;
                        hold_cnt <= '0;
                    end else if (din_s2 == SYNC_WORD1) begin
                        if (hold_done) begin
                            state    <= ST_ACTIVE;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end else begin
                        hold_cnt <= '0;
                    end
                end
                ST_ACTIVE: hold_cnt <= '0;
                default: begin
                    state    <= ST_UNSYNC;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    // One register stage between edge detect and FIFO write sets the 4-clk strobe-to-valid latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_req  <= 1'b0;
            rx_word <= '0;
        end else begin
            rx_req  <= active && bclk_rise && !rnw_s2 && !resync;
            rx_word <= din_s2;
        end
    end

    assign rx_push  = rx_req && !resync;
    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_valid && rx_ready;

    par_bus_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .flush     (resync),
        .push      (rx_push),
        .push_data (rx_word),
        .pop       (rx_pop),
        .head      (rx_data),
        .count     (rx_count),
        .empty     (rx_empty),
        .full      (rx_full)
    );

    assign tx_ready = !tx_full;
    assign tx_push  = tx_valid && tx_ready;
    assign tx_take  = active && bclk_fall && rnw_s2 && !resync;
    assign tx_pop   = tx_take && !tx_empty;

    par_bus_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .flush     (resync),
        .push      (tx_push),
        .push_data (tx_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .count     (tx_count),
        .empty     (tx_empty),
        .full      (tx_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_data_out <= '0;
            rx_overflow  <= 1'b0;
            tx_underflow <= 1'b0;
        end else begin
            if (tx_take) begin
                bus_data_out <= tx_empty ? FILL_WORD : tx_head;
            end
            rx_overflow  <= (rx_push && rx_full && !rx_pop) || (rx_overflow && !clear_flags);
            tx_underflow <= (tx_take && tx_empty) || (tx_underflow && !clear_flags);
        end
    end

    assign bus_data_oe = active && rnw_s2;
    assign synced      = active;

endmodule

// File: tb/tb_par_bus_slave.sv
// Scoreboard bench for par_bus_slave: 8-bit instance for protocol/flags, 16-bit instance for width.
module tb_par_bus_slave;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       bus_clk, bus_rnw, bus_data_oe, resync, clear_flags;
    logic [7:0] bus_data_in, bus_data_out, rx_data, tx_data;
    logic       rx_valid, rx_ready, tx_valid, tx_ready, synced, rx_overflow, tx_underflow;
    logic [4:0] rx_count, tx_count;

    logic        w_clk, w_rnw, w_oe, w_rx_valid, w_tx_valid, w_tx_ready, w_synced, w_ovf, w_unf;
    logic [15:0] w_din, w_out, w_rx_data, w_tx_data;
    logic [4:0]  w_rx_count, w_tx_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    par_bus_slave dut (
        .clk(clk), .reset(reset), .bus_clk(bus_clk), .bus_rnw(bus_rnw),
        .bus_data_in(bus_data_in), .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
        .resync(resync), .clear_flags(clear_flags), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .synced(synced), .rx_overflow(rx_overflow), .tx_underflow(tx_underflow),
        .rx_count(rx_count), .tx_count(tx_count)
    );

    par_bus_slave #(.DATA_WIDTH(16), .SYNC_WORD0(16'h00B8), .SYNC_WORD1(16'h008B)) dut16 (
        .clk(clk), .reset(reset), .bus_clk(w_clk), .bus_rnw(w_rnw),
        .bus_data_in(w_din), .bus_data_out(w_out), .bus_data_oe(w_oe),
        .resync(1'b0), .clear_flags(1'b0), .rx_data(w_rx_data), .rx_valid(w_rx_valid),
        .rx_ready(1'b0), .tx_data(w_tx_data), .tx_valid(w_tx_valid), .tx_ready(w_tx_ready),
        .synced(w_synced), .rx_overflow(w_ovf), .tx_underflow(w_unf),
        .rx_count(w_rx_count), .tx_count(w_tx_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] hash(input int i);
        return 8'((i * 37 + 11) ^ (i << 4));
    endfunction

    task automatic hold_word(input logic [7:0] w, input int n);
        bus_data_in = w;
        cyc(n);
    endtask

    task automatic do_sync();
        bus_rnw = 1'b0;
        bus_clk = 1'b1;
        hold_word(8'hB8, 3);
        hold_word(8'h8B, 3);
        cyc(3);
    endtask

    task automatic bus_write(input logic [7:0] w, input bit expect_kept);
        bus_rnw     = 1'b0;
        bus_clk     = 1'b0;
        bus_data_in = w;
        cyc(3);
        if (expect_kept) rx_q.push_back(w);
        bus_clk = 1'b1;
        cyc(4);
    endtask

    task automatic tx_push(input logic [7:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
        tx_q.push_back(w);
    endtask

    task automatic bus_read();
        logic [7:0] e;
        bus_rnw = 1'b1;
        cyc(3);
        check_eq("oe_read", 32'(bus_data_oe), 32'd1);
        e = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hFF;
        bus_clk = 1'b0;
        cyc(4);
        check_eq("bus_data_out", 32'(bus_data_out), 32'(e));
        bus_clk = 1'b1;
        cyc(3);
        check_eq("bus_data_hold", 32'(bus_data_out), 32'(e));
    endtask

    task automatic drain_rx();
        int waited;
        while (rx_q.size() > 0) begin
            waited = 0;
            while (!rx_valid && waited < 20) begin
                cyc(1);
                waited++;
            end
            check_eq("rx_valid", 32'(rx_valid), 32'd1);
            check_eq("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
            rx_ready = 1'b1;
            cyc(1);
            rx_ready = 1'b0;
        end
        check_eq("rx_drained", 32'(rx_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; bus_clk = 1'b0; bus_rnw = 1'b0; bus_data_in = '0;
        resync = 1'b0; clear_flags = 1'b0; rx_ready = 1'b0; tx_data = '0; tx_valid = 1'b0;
        w_clk = 1'b0; w_rnw = 1'b0; w_din = '0; w_tx_data = '0; w_tx_valid = 1'b0;
        cyc(2);
        check_eq("rst_flags", 32'({bus_data_oe, synced, rx_valid, rx_overflow, tx_underflow, tx_ready}), 32'b000001);
        check_eq("rst_counts", 32'({rx_count, tx_count}), 32'd0);
        check_eq("rst_data_out", 32'(bus_data_out), 32'd0);
        reset = 1'b1;
        cyc(2);

        // Broken pattern must not lock.
        bus_clk = 1'b1;
        hold_word(8'hB8, 3);
        hold_word(8'h55, 3);
        hold_word(8'h8B, 3);
        cyc(3);
        check_eq("sync_bad_seq", 32'(synced), 32'd0);
        do_sync();
        check_eq("sync_ok", 32'(synced), 32'd1);

        // First write with strobe-to-valid latency.
        bus_clk = 1'b0;
        bus_data_in = 8'h01;
        cyc(3);
        rx_q.push_back(8'h01);
        bus_clk = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_eq("rx_lat3", 32'(rx_valid), 32'd0);
        @(posedge clk);
        #1 check_eq("rx_lat4", 32'(rx_valid), 32'd1);
        cyc(2);
        drain_rx();

        for (int i = 0; i < 16; i++) bus_write(hash(i), 1'b1);
        check_eq("rx_count_full", 32'(rx_count), 32'd16);
        check_eq("ovf_not_yet", 32'(rx_overflow), 32'd0);
        bus_write(8'h77, 1'b0);
        check_eq("ovf_set", 32'(rx_overflow), 32'd1);
        check_eq("rx_count_held", 32'(rx_count), 32'd16);
        drain_rx();

        tx_push(8'hA5);
        tx_push(8'h3C);
        check_eq("tx_count2", 32'(tx_count), 32'd2);
        bus_read();
        bus_read();
        check_eq("unf_clear", 32'(tx_underflow), 32'd0);
        bus_read();
        check_eq("unf_set", 32'(tx_underflow), 32'd1);

        // Resync with both FIFOs half full.
        bus_rnw = 1'b0;
        cyc(3);
        for (int i = 0; i < 8; i++) bus_write(hash(i + 40), 1'b1);
        for (int i = 0; i < 8; i++) tx_push(8'(i + 16));
        check_eq("rx_count_half", 32'(rx_count), 32'd8);
        check_eq("tx_count_half", 32'(tx_count), 32'd8);
        resync = 1'b1;
        cyc(1);
        check_eq("resync_counts", 32'({rx_count, tx_count}), 32'd0);
        check_eq("resync_synced", 32'(synced), 32'd0);
        check_eq("resync_flags", 32'({rx_overflow, tx_underflow}), 32'b11);
        resync = 1'b0;
        rx_q.delete();
        tx_q.delete();
        clear_flags = 1'b1;
        cyc(1);
        clear_flags = 1'b0;
        check_eq("flags_cleared", 32'({rx_overflow, tx_underflow}), 32'b00);

        // clear_flags on the very cycle an overflow is recorded.
        do_sync();
        for (int i = 0; i < 16; i++) bus_write(hash(i + 80), 1'b0);
        bus_clk = 1'b0;
        bus_data_in = 8'hEE;
        cyc(3);
        bus_clk = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) clear_flags = 1'b1;
        cyc(1);
        clear_flags = 1'b0;
        check_eq("ovf_beats_clear", 32'(rx_overflow), 32'd1);

        // Reset in the middle of a read.
        tx_push(8'hC3);
        tx_push(8'h5A);
        bus_rnw = 1'b1;
        cyc(3);
        bus_clk = 1'b0;
        cyc(4);
        check_eq("rd_before_rst", 32'(bus_data_out), 32'(tx_q.pop_front()));
        bus_clk = 1'b1;
        cyc(3);
        bus_clk = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_flags", 32'({bus_data_oe, synced, rx_valid, rx_overflow, tx_underflow, tx_ready}), 32'b000001);
        check_eq("arst_counts", 32'({rx_count, tx_count}), 32'd0);
        check_eq("arst_data_out", 32'(bus_data_out), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tx_q.delete();
        bus_clk = 1'b1;
        bus_rnw = 1'b0;
        cyc(6);
        check_eq("post_rst_discard", 32'({rx_count, tx_count, bus_data_out}), 32'd0);

        // 16-bit round trip.
        w_rnw = 1'b0;
        w_clk = 1'b1;
        w_din = 16'h00B8;
        cyc(3);
        w_din = 16'h008B;
        cyc(6);
        check_eq("w_synced", 32'(w_synced), 32'd1);
        w_clk = 1'b0;
        w_din = 16'hBEEF;
        cyc(3);
        w_clk = 1'b1;
        cyc(5);
        check_eq("w_rx_valid", 32'(w_rx_valid), 32'd1);
        check_eq("w_rx_data", 32'(w_rx_data), 32'h0000BEEF);
        w_tx_data = 16'hBEEF;
        w_tx_valid = 1'b1;
        cyc(1);
        w_tx_valid = 1'b0;
        w_rnw = 1'b1;
        cyc(3);
        w_clk = 1'b0;
        cyc(4);
        check_eq("w_oe", 32'(w_oe), 32'd1);
        check_eq("w_out", 32'(w_out), 32'h0000BEEF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
